// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types, default widths and sizing helpers
// for the data-memory arbiter and its round-robin picker.
package dmem_arb_pkg;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_t;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 16;
    localparam int LOCK_MAX   = 15;
    localparam int LOCK_CNT_W = $clog2(LOCK_MAX + 1);

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int max);
        return (max > 0) ? $clog2(max + 1) : 1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick among eligible requests,
// searching upward from the slot after last_i with wrap-around.
module rr_picker
    import dmem_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [N-1:0]  mask_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [N-1:0] cand;

    assign cand = req_i & mask_i;

    always_comb begin
        int j;
        j     = 0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(last_i) + k) % N;
            if (!any_o && cand[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of the single-port dmem with lock
// and lock timeout. DMEM_ARBITER_STATS_EN adds grant/wait counters.
module dmem_arbiter #(
    parameter int N_REQ    = 2,
    parameter int DATA_W   = dmem_arb_pkg::DATA_W,
    parameter int ADDR_W   = dmem_arb_pkg::ADDR_W,
    parameter int LOCK_MAX = dmem_arb_pkg::LOCK_MAX
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ-1:0]         req_lock,
    input  logic [N_REQ-1:0]         req_we,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_wdata,
    output logic [N_REQ-1:0]         req_ready,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     locked,
    output logic [2:0]               lock_owner,
`ifdef DMEM_ARBITER_STATS_EN
    input  logic [2:0]               stat_sel,
    output logic [15:0]              stat_grant,
    output logic [15:0]              stat_wait,
`endif
    output logic                     lock_err
);

    import dmem_arb_pkg::*;

    localparam int IW = idx_w(N_REQ);
    localparam int CW = cnt_w(LOCK_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

    arb_state_t        state_q, state_d;
    logic [IW-1:0]     last_q, last_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              lock_err_q, lock_err_d;

    logic [N_REQ-1:0]  elig;
    logic [N_REQ-1:0]  gnt;
    logic [IW-1:0]     win;
    logic              xfer;
    logic              win_we;
    logic              win_lock;

    // No grants while reset is held, so nothing reaches dmem.
    always_comb begin
        elig = '0;
        if (!reset) begin
            if (state_q == LOCKED) begin
                elig[owner_q] = 1'b1;
            end else begin
                elig = '1;
            end
        end
    end

    rr_picker #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .req_i  (req_valid),
        .mask_i (elig),
        .last_i (last_q),
        .gnt_o  (gnt),
        .idx_o  (win),
        .any_o  (xfer)
    );

    assign win_we   = req_we[win];
    assign win_lock = req_lock[win];

    assign req_ready = gnt;
    assign mem_we    = xfer & win_we;
    assign mem_addr  = xfer ? req_addr[int'(win)*ADDR_W +: ADDR_W] : '0;
    assign mem_wdata = xfer ? req_wdata[int'(win)*DATA_W +: DATA_W] : '0;

    assign rsp_valid_d = gnt;
    assign rdata_d     = (xfer && !win_we) ? mem_rdata : '0;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        lock_err_d = 1'b0;
        if (xfer) begin
            last_d = win;
        end
        unique case (state_q)
            IDLE: begin
                if (xfer && win_lock) begin
                    state_d = LOCKED;
                    owner_d = win;
                    cnt_d   = '0;
                end
            end
            LOCKED: begin
                if (xfer) begin
                    cnt_d = '0;
                    if (!win_lock) begin
                        state_d = IDLE;
                        owner_d = '0;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // Owner went quiet too long: drop the lock.
                    state_d    = IDLE;
                    owner_d    = '0;
                    cnt_d      = '0;
                    lock_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= IW'(N_REQ - 1);
            owner_q     <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rdata_q     <= '0;
            lock_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            lock_err_q  <= lock_err_d;
        end
    end

    // Reset takes effect on the outputs at once, killing any in-flight response.
    assign rsp_valid  = reset ? '0 : rsp_valid_q;
    assign rsp_rdata  = reset ? '0 : rdata_q;
    assign locked     = !reset && (state_q == LOCKED);
    assign lock_owner = locked ? 3'(owner_q) : 3'd0;
    assign lock_err   = !reset && lock_err_q;

`ifdef DMEM_ARBITER_STATS_EN
    logic [15:0] grant_cnt_q [N_REQ];
    logic [15:0] wait_cnt_q  [N_REQ];

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (reset) begin
                grant_cnt_q[i] <= '0;
                wait_cnt_q[i]  <= '0;
            end else begin
                if (gnt[i] && grant_cnt_q[i] != 16'hFFFF) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
                end
                if (req_valid[i] && !gnt[i] && wait_cnt_q[i] != 16'hFFFF) begin
                    wait_cnt_q[i] <= wait_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        stat_grant = '0;
        stat_wait  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (stat_sel == 3'(i)) begin
                stat_grant = grant_cnt_q[i];
                stat_wait  = wait_cnt_q[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized traffic, checked
// cycle by cycle against a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int N        = 2;
    localparam int W        = 16;
    localparam int LOCK_MAX = 15;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid, req_lock, req_we;
    logic [N*W-1:0] req_addr, req_wdata;
    logic [N-1:0]   req_ready, rsp_valid;
    logic [W-1:0]   rsp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic           mem_we, locked, lock_err;
    logic [2:0]     lock_owner;
`ifdef DMEM_ARBITER_STATS_EN
    logic [2:0]     stat_sel;
    logic [15:0]    stat_grant, stat_wait;
`endif

    logic [15:0] mem [0:65535];

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    int          holder;
    int          idle;
    int          last;
    int          pend_who;
    logic [15:0] pend_data;
    bit          pend_err;
    logic [15:0] rmem [int];
    int          gcnt [N];
    int          wcnt [N];

    always #5 clk = ~clk;

    dmem_arbiter #(
        .N_REQ    (N),
        .DATA_W   (W),
        .ADDR_W   (W),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_lock   (req_lock),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .locked     (locked),
        .lock_owner (lock_owner),
`ifdef DMEM_ARBITER_STATS_EN
        .stat_sel   (stat_sel),
        .stat_grant (stat_grant),
        .stat_wait  (stat_wait),
`endif
        .lock_err   (lock_err)
    );

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] mget(input logic [15:0] a);
        return rmem.exists(int'(a)) ? rmem[int'(a)] : 16'h0;
    endfunction

    // One clock cycle: drive, check against the model, advance the model.
    task automatic cyc(input bit rst, input logic [1:0] v,
                       input logic [1:0] lk, input logic [1:0] we,
                       input logic [15:0] a0, input logic [15:0] a1,
                       input logic [15:0] d0, input logic [15:0] d1);
        int          win;
        int          idx;
        logic [15:0] wa [N];
        logic [15:0] wd [N];
        logic [N-1:0] exp_rdy;
        wa[0] = a0; wa[1] = a1;
        wd[0] = d0; wd[1] = d1;
        reset     = rst;
        req_valid = v;
        req_lock  = lk;
        req_we    = we;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
        #1;
        win = -1;
        if (!rst) begin
            for (int k = 1; k <= N; k++) begin
                idx = (last + k) % N;
                if (win < 0 && v[idx] && (holder < 0 || holder == idx))
                    win = idx;
            end
        end
        exp_rdy = '0;
        if (win >= 0) exp_rdy[win] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("mem_we", 32'(mem_we), (win >= 0) ? 32'(we[win]) : 32'd0);
        chk("mem_addr", 32'(mem_addr), (win >= 0) ? 32'(wa[win]) : 32'd0);
        chk("mem_wdata", 32'(mem_wdata), (win >= 0) ? 32'(wd[win]) : 32'd0);
        if (rst || pend_who < 0) begin
            chk("rsp_valid", 32'(rsp_valid), 32'd0);
        end else begin
            chk("rsp_valid", 32'(rsp_valid), 32'd1 << pend_who);
            chk("rsp_rdata", 32'(rsp_rdata), 32'(pend_data));
        end
        if (rst) chk("rsp_rdata_rst", 32'(rsp_rdata), 32'd0);
        chk("locked", 32'(locked), 32'(!rst && holder >= 0));
        chk("lock_owner", 32'(lock_owner),
            (!rst && holder >= 0) ? 32'(holder) : 32'd0);
        chk("lock_err", 32'(lock_err), 32'(!rst && pend_err));

        if (rst) begin
            holder   = -1;
            idle     = 0;
            last     = N - 1;
            pend_who = -1;
            pend_err = 1'b0;
            for (int i = 0; i < N; i++) begin
                gcnt[i] = 0;
                wcnt[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (win == i) gcnt[i]++;
                else if (v[i]) wcnt[i]++;
            end
            pend_err = 1'b0;
            pend_who = win;
            if (win >= 0) begin
                pend_data = we[win] ? 16'h0 : mget(wa[win]);
                if (we[win]) rmem[int'(wa[win])] = wd[win];
                last = win;
                if (holder < 0) begin
                    if (lk[win]) begin
                        holder = win;
                        idle   = 0;
                    end
                end else begin
                    idle = 0;
                    if (!lk[win]) holder = -1;
                end
            end else if (holder >= 0) begin
                idle++;
                if (idle == LOCK_MAX) begin
                    holder   = -1;
                    idle     = 0;
                    pend_err = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int           p [N];
        int           pick [4];
        logic [1:0]   v, lk, we;
        logic [15:0]  a0, a1;
        pick = '{0, 20, 60, 95};
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
        reset     = 1'b1;
        req_valid = '0;
        req_lock  = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
`ifdef DMEM_ARBITER_STATS_EN
        stat_sel  = 3'd0;
`endif
        holder    = -1;
        idle      = 0;
        last      = N - 1;
        pend_who  = -1;
        pend_err  = 1'b0;
        pend_data = 16'h0;
        for (int i = 0; i < N; i++) begin
            p[i] = 0;
            gcnt[i] = 0;
            wcnt[i] = 0;
        end

        cyc(1, 2'b00, 2'b00, 2'b00, 16'd0, 16'd0, 16'd0, 16'd0);
        cyc(1, 2'b11, 2'b00, 2'b00, 16'd1, 16'd2, 16'd0, 16'd0);

        // Write 0x0096 to 84, then read it back
        cyc(0, 2'b01, 2'b00, 2'b01, 16'd84, 16'd0, 16'h0096, 16'd0);
        cyc(0, 2'b01, 2'b00, 2'b00, 16'd84, 16'd0, 16'd0, 16'd0);
        cyc(0, 2'b00, 2'b00, 2'b00, 16'd0, 16'd0, 16'd0, 16'd0);

        // Both requesting: grants alternate
        repeat (4) cyc(0, 2'b11, 2'b00, 2'b00, 16'd84, 16'd84, 16'd0, 16'd0);
        cyc(0, 2'b00, 2'b00, 2'b00, 16'd0, 16'd0, 16'd0, 16'd0);

        // Requester 1 locks; requester 0 is shut out until release
        cyc(0, 2'b10, 2'b10, 2'b00, 16'd0, 16'd84, 16'd0, 16'd0);
        repeat (3) cyc(0, 2'b01, 2'b00, 2'b00, 16'd3, 16'd0, 16'd0, 16'd0);
        cyc(0, 2'b11, 2'b00, 2'b10, 16'd3, 16'd7, 16'd0, 16'hBEEF);
        cyc(0, 2'b01, 2'b00, 2'b00, 16'd7, 16'd0, 16'd0, 16'd0);

        // Requester 0 locks and goes quiet: timeout releases it
        cyc(0, 2'b01, 2'b01, 2'b00, 16'd7, 16'd0, 16'd0, 16'd0);
        repeat (18) cyc(0, 2'b10, 2'b00, 2'b00, 16'd0, 16'd84, 16'd0, 16'd0);

        // Reset right after a locked read
        cyc(0, 2'b01, 2'b01, 2'b00, 16'd84, 16'd0, 16'd0, 16'd0);
        cyc(1, 2'b11, 2'b00, 2'b00, 16'd84, 16'd84, 16'd0, 16'd0);
        cyc(0, 2'b00, 2'b00, 2'b00, 16'd0, 16'd0, 16'd0, 16'd0);

        // Randomized traffic with per-phase request densities
        for (int c = 0; c < 4000; c++) begin
            if (c % 32 == 0) begin
                for (int i = 0; i < N; i++) p[i] = pick[$urandom_range(3)];
            end
            for (int i = 0; i < N; i++) begin
                v[i]  = ($urandom_range(99) < p[i]);
                lk[i] = ($urandom_range(3) == 0);
                we[i] = 1'($urandom_range(1));
            end
            a0 = 16'($urandom_range(15));
            a1 = 16'($urandom_range(15));
            cyc(($urandom_range(399) == 0), v, lk, we, a0, a1,
                16'($urandom), 16'($urandom));
        end

`ifdef DMEM_ARBITER_STATS_EN
        for (int i = 0; i < N; i++) begin
            stat_sel = 3'(i);
            #1;
            chk("stat_grant", 32'(stat_grant), 32'(gcnt[i]));
            chk("stat_wait", 32'(stat_wait), 32'(wcnt[i]));
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
